// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding and NREQ bounds.
package uart_arb_pkg;

  localparam int NREQ_MIN = 2;
  localparam int NREQ_MAX = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } arb_state_e;

  // Index width for a vector of n entries; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester byte streams, uart_tx handshake and arbiter status in one bundle.
interface uart_tx_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0][7:0] req_data;
  logic [NREQ-1:0]      req_last;
  logic [NREQ-1:0]      req_ready;
  logic [7:0]           tx_data;
  logic                 tx_start;
  logic                 tx_ready;
  logic [NREQ-1:0]      grant;
  logic                 busy;
  logic                 drop;

  // Requesters plus the uart_tx instance.
  modport master (
    output req_valid, req_data, req_last, tx_ready,
    input  req_ready, tx_data, tx_start, grant, busy, drop
  );

  // The arbiter itself.
  modport slave (
    input  req_valid, req_data, req_last, tx_ready,
    output req_ready, tx_data, tx_start, grant, busy, drop
  );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin winner select: first set request at or above ptr, with wrap.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] win,
  output logic [IW-1:0]   idx
);

  logic found;
  int   c;

  // Walk NREQ slots starting at ptr; the first requester hit wins.
  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    c     = 0;
    for (int k = 0; k < NREQ; k++) begin
      c = int'(ptr) + k;
      if (c >= NREQ) c = c - NREQ;
      if (!found && req[c]) begin
        found  = 1'b1;
        win[c] = 1'b1;
        idx    = IW'(c);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between NREQ byte streams; a grant covers a whole message.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int HOLD_MAX = 0
) (
  input logic              clk,
  input logic              rst,
  uart_tx_arbiter_if.slave bus
);

  localparam int IW = idx_w(NREQ);
  localparam int HW = idx_w(HOLD_MAX + 1);

  arb_state_e      state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic            busy_q, busy_d;
  logic            tx_start_q, tx_start_d;
  logic            drop_q, drop_d;
  logic            last_q, last_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [HW-1:0]   hold_q, hold_d;

  logic [NREQ-1:0] pick_win;
  logic [IW-1:0]   pick_idx;
  logic            owner_valid;
  logic            accept;
  logic [IW-1:0]   next_ptr;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req (bus.req_valid),
    .ptr (ptr_q),
    .win (pick_win),
    .idx (pick_idx)
  );

  assign owner_valid = bus.req_valid[owner_q];
  assign accept      = (state_q == ST_SEND) && bus.tx_ready && owner_valid;
  assign next_ptr    = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + 1'b1;

  // Only the owner may hand over a byte, and only while uart_tx is idle.
  assign bus.req_ready = (state_q == ST_SEND) ? (grant_q & {NREQ{bus.tx_ready}}) : '0;

  assign bus.tx_data  = tx_data_q;
  assign bus.tx_start = tx_start_q;
  assign bus.grant    = grant_q;
  assign bus.busy     = busy_q;
  assign bus.drop     = drop_q;

  // Next-state and registered-output logic for the grant/transmit sequence.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    busy_d     = busy_q;
    tx_start_d = 1'b0;
    drop_d     = 1'b0;
    last_d     = last_q;
    tx_data_d  = tx_data_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    hold_d     = hold_q;
    case (state_q)
      ST_IDLE: begin
        if (|bus.req_valid) begin
          grant_d = pick_win;
          owner_d = pick_idx;
          busy_d  = 1'b1;
          hold_d  = '0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (accept) begin
          tx_data_d  = bus.req_data[owner_q];
          last_d     = bus.req_last[owner_q];
          tx_start_d = 1'b1;
          hold_d     = '0;
          state_d    = ST_WAIT_BUSY;
        end else if (HOLD_MAX != 0 && !owner_valid) begin
          // Owner went quiet mid-message: revoke once the idle count reaches HOLD_MAX.
          if (int'(hold_q) + 1 >= HOLD_MAX) begin
            drop_d  = 1'b1;
            grant_d = '0;
            busy_d  = 1'b0;
            ptr_d   = next_ptr;
            hold_d  = '0;
            state_d = ST_IDLE;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
      end
      ST_WAIT_BUSY: begin
        // tx_ready may linger high after start; wait until uart_tx goes busy.
        if (!bus.tx_ready) state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (bus.tx_ready) begin
          if (last_q) begin
            grant_d = '0;
            busy_d  = 1'b0;
            ptr_d   = next_ptr;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_SEND;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset abandons any character in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      busy_q     <= 1'b0;
      tx_start_q <= 1'b0;
      drop_q     <= 1'b0;
      last_q     <= 1'b0;
      tx_data_q  <= 8'h00;
      ptr_q      <= '0;
      owner_q    <= '0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      busy_q     <= busy_d;
      tx_start_q <= tx_start_d;
      drop_q     <= drop_d;
      last_q     <= last_d;
      tx_data_q  <= tx_data_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      hold_q     <= hold_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a behavioural uart_tx model.
module tb_uart_tx_arbiter;

  localparam int NREQ     = 4;
  localparam int HOLD_MAX = 16;
  localparam int CHAR     = 10;

  typedef struct packed {
    logic [7:0] who;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_tx_arbiter_if #(.NREQ(NREQ)) bus ();

  uart_tx_arbiter #(.NREQ(NREQ), .HOLD_MAX(HOLD_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int early = 0;
  int u_pre = 0;
  int u_cnt = 0;

  // uart_tx stand-in: optional lingering ready, then CHAR cycles busy.
  always @(posedge clk) begin
    if (rst) begin
      bus.tx_ready <= 1'b1;
      u_pre        <= 0;
      u_cnt        <= 0;
    end else if (bus.tx_start) begin
      u_pre <= early;
      u_cnt <= CHAR;
      if (early == 0) bus.tx_ready <= 1'b0;
    end else if (u_pre > 0) begin
      u_pre <= u_pre - 1;
      if (u_pre == 1) bus.tx_ready <= 1'b0;
    end else if (u_cnt > 0) begin
      u_cnt <= u_cnt - 1;
      if (u_cnt == 1) bus.tx_ready <= 1'b1;
    end
  end

  exp_t            sb[$];
  logic [8:0]      rq[NREQ][$];
  int              start_cyc[$];
  logic [NREQ-1:0] acc = '0;
  int n_assert = 0, n_fail = 0, cyc = 0, ready_viol = 0, starts = 0, drops = 0;

  function automatic bit rq_empty();
    for (int i = 0; i < NREQ; i++) if (rq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drive();
    logic [8:0] t;
    for (int i = 0; i < NREQ; i++) begin
      if (rq[i].size() > 0) begin
        t = rq[i][0];
        bus.req_valid[i] = 1'b1;
        bus.req_data[i]  = t[7:0];
        bus.req_last[i]  = t[8];
      end else begin
        bus.req_valid[i] = 1'b0;
        bus.req_data[i]  = 8'h00;
        bus.req_last[i]  = 1'b0;
      end
    end
  endtask

  task automatic push(input int who, input logic [7:0] data, input logic last);
    exp_t e;
    rq[who].push_back({last, data});
    e.who  = 8'(who);
    e.data = data;
    sb.push_back(e);
  endtask

  // One clock: retire accepted bytes, present the next ones, then sample at negedge.
  task automatic step();
    exp_t            e;
    logic [NREQ-1:0] eg;
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) if (acc[i] && rq[i].size() > 0) void'(rq[i].pop_front());
    drive();
    cyc++;
    @(negedge clk);
    acc = bus.req_valid & bus.req_ready;
    if ((bus.req_ready & ~bus.grant) != '0) ready_viol++;
    if (bus.drop === 1'b1) drops++;
    if (bus.tx_start === 1'b1) begin
      starts++;
      start_cyc.push_back(cyc);
      n_assert++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL tx_unexpected: got tx_start with data %02h grant %b, required no tx_start",
                 bus.tx_data, bus.grant);
      end else begin
        e = sb.pop_front();
        eg = '0;
        eg[e.who] = 1'b1;
        if (bus.tx_data !== e.data || bus.grant !== eg) begin
          n_fail++;
          $display("FAIL tx_char: got data %02h grant %b, required data %02h grant %b",
                   bus.tx_data, bus.grant, e.data, eg);
        end
      end
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k = 0;
    while ((bus.busy !== 1'b0 || sb.size() != 0 || !rq_empty()) && k < budget) begin
      step();
      k++;
    end
    n_assert++;
    if (k >= budget) begin
      n_fail++;
      $display("FAIL %s_idle: still busy after %0d cycles (%0d chars pending), required idle",
               name, budget, sb.size());
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sb.delete();
    for (int i = 0; i < NREQ; i++) rq[i].delete();
    acc   = '0;
    early = 0;
    drive();
    repeat (2) step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive();
    repeat (3) step();
    n_assert += 6;
    if (bus.grant !== 4'b0000) begin n_fail++; $display("FAIL rst_grant: got %b, required 0000", bus.grant); end
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b, required 0", bus.busy); end
    if (bus.tx_start !== 1'b0) begin n_fail++; $display("FAIL rst_start: got %b, required 0", bus.tx_start); end
    if (bus.tx_data !== 8'h00) begin n_fail++; $display("FAIL rst_data: got %02h, required 00", bus.tx_data); end
    if (bus.drop !== 1'b0) begin n_fail++; $display("FAIL rst_drop: got %b, required 0", bus.drop); end
    if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL rst_ready: got %b, required 0000", bus.req_ready); end
    rst = 1'b0;
  endtask

  task automatic test_single_3byte();
    int s0;
    start_cyc.delete();
    ready_viol = 0;
    push(0, 8'h41, 1'b0);
    push(0, 8'h42, 1'b0);
    push(0, 8'h43, 1'b1);
    step();
    n_assert++;
    if (bus.grant !== 4'b0000) begin n_fail++; $display("FAIL single_pregrant: got %b, required 0000", bus.grant); end
    step();
    n_assert += 3;
    if (bus.grant !== 4'b0001) begin n_fail++; $display("FAIL single_grant: got %b, required 0001", bus.grant); end
    if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b, required 1", bus.busy); end
    if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_ready: got %b, required 0001", bus.req_ready); end
    s0 = starts;
    step();
    n_assert++;
    if (starts != s0 + 1) begin n_fail++; $display("FAIL single_start_lat: got %0d starts, required %0d", starts - s0, 1); end
    step();
    n_assert++;
    if (bus.tx_start !== 1'b0) begin n_fail++; $display("FAIL single_start_width: got %b, required 0", bus.tx_start); end
    wait_idle("single", 200);
    n_assert += 4;
    if (bus.grant !== 4'b0000 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL single_release: got grant %b busy %b, required 0000 0", bus.grant, bus.busy);
    end
    if (start_cyc.size() != 3) begin
      n_fail++; $display("FAIL single_count: got %0d starts, required 3", start_cyc.size());
    end else if (start_cyc[1] - start_cyc[0] != CHAR + 3) begin
      n_fail++; $display("FAIL single_gap: got %0d, required %0d", start_cyc[1] - start_cyc[0], CHAR + 3);
    end
    if (ready_viol != 0) begin n_fail++; $display("FAIL single_ready_nonowner: got %0d, required 0", ready_viol); end
    if (drops != 0) begin n_fail++; $display("FAIL single_drop: got %0d, required 0", drops); end
  endtask

  task automatic test_round_robin();
    do_reset();
    start_cyc.delete();
    ready_viol = 0;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < NREQ; i++) push(i, 8'h30 + 8'(i), 1'b1);
      wait_idle("rr", 300);
    end
    n_assert += 3;
    if (start_cyc.size() < 2 || start_cyc[1] - start_cyc[0] != CHAR + 4) begin
      n_fail++; $display("FAIL rr_owner_gap: got %0d starts, first gap %0d, required gap %0d",
                         start_cyc.size(), (start_cyc.size() < 2) ? 0 : start_cyc[1] - start_cyc[0], CHAR + 4);
    end
    if (ready_viol != 0) begin n_fail++; $display("FAIL rr_ready_nonowner: got %0d, required 0", ready_viol); end
    if (drops != 0) begin n_fail++; $display("FAIL rr_drop: got %0d, required 0", drops); end
  endtask

  task automatic test_msg_lock();
    int k = 0;
    ready_viol = 0;
    push(1, 8'h58, 1'b0);
    push(1, 8'h59, 1'b1);
    while (bus.grant !== 4'b0010 && k < 10) begin step(); k++; end
    n_assert++;
    if (bus.grant !== 4'b0010) begin n_fail++; $display("FAIL lock_grant: got %b, required 0010", bus.grant); end
    push(0, 8'h5A, 1'b1);
    wait_idle("lock", 200);
    n_assert++;
    if (ready_viol != 0) begin n_fail++; $display("FAIL lock_ready0: got %0d, required 0", ready_viol); end
  endtask

  task automatic test_hold_timeout();
    int k = 0, s0, s;
    push(1, 8'h44, 1'b0);
    while (bus.grant !== 4'b0010 && k < 10) begin step(); k++; end
    n_assert++;
    if (bus.grant !== 4'b0010) begin n_fail++; $display("FAIL hold_grant: got %b, required 0010", bus.grant); end
    push(2, 8'h45, 1'b1);
    s0 = starts;
    k = 0;
    while (starts == s0 && k < 10) begin step(); k++; end
    k = 0;
    while (bus.req_ready[1] !== 1'b1 && k < CHAR + 10) begin step(); k++; end
    s = cyc;
    k = 0;
    while (bus.drop !== 1'b1 && k < 3 * HOLD_MAX) begin step(); k++; end
    n_assert += 3;
    if (bus.drop !== 1'b1 || cyc - s != HOLD_MAX) begin
      n_fail++; $display("FAIL hold_drop_time: got drop %b after %0d cycles, required 1 after %0d", bus.drop, cyc - s, HOLD_MAX);
    end
    if (bus.grant !== 4'b0000 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL hold_release: got grant %b busy %b, required 0000 0", bus.grant, bus.busy);
    end
    step();
    if (bus.drop !== 1'b0 || bus.grant !== 4'b0100) begin
      n_fail++; $display("FAIL hold_next: got drop %b grant %b, required 0 0100", bus.drop, bus.grant);
    end
    wait_idle("hold", 200);
    n_assert++;
    if (drops != 1) begin n_fail++; $display("FAIL hold_drop_count: got %0d, required 1", drops); end
  endtask

  task automatic test_reset_mid();
    int k = 0, s0;
    push(3, 8'h46, 1'b1);
    s0 = starts;
    while (starts == s0 && k < 10) begin step(); k++; end
    repeat (3) step();
    rst = 1'b1;
    step();
    n_assert += 6;
    if (bus.grant !== 4'b0000) begin n_fail++; $display("FAIL mid_grant: got %b, required 0000", bus.grant); end
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b, required 0", bus.busy); end
    if (bus.tx_start !== 1'b0) begin n_fail++; $display("FAIL mid_start: got %b, required 0", bus.tx_start); end
    if (bus.tx_data !== 8'h00) begin n_fail++; $display("FAIL mid_data: got %02h, required 00", bus.tx_data); end
    if (bus.drop !== 1'b0) begin n_fail++; $display("FAIL mid_drop: got %b, required 0", bus.drop); end
    if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL mid_ready: got %b, required 0000", bus.req_ready); end
    rst = 1'b0;
    s0 = starts;
    repeat (CHAR + 10) step();
    n_assert++;
    if (starts != s0) begin n_fail++; $display("FAIL mid_no_restart: got %0d starts, required 0", starts - s0); end
  endtask

  task automatic test_early_ready();
    int k = 0, s0;
    early = 2;
    push(0, 8'h47, 1'b0);
    push(0, 8'h48, 1'b1);
    s0 = starts;
    while (starts == s0 && k < 10) begin step(); k++; end
    for (int j = 0; j < 3; j++) begin
      step();
      n_assert++;
      if (bus.req_ready !== 4'b0000 || bus.tx_start !== 1'b0) begin
        n_fail++; $display("FAIL early_wait%0d: got ready %b start %b, required 0000 0", j, bus.req_ready, bus.tx_start);
      end
    end
    wait_idle("early", 200);
    early = 0;
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    test_reset();
    test_single_3byte();
    test_round_robin();
    test_msg_lock();
    test_hold_timeout();
    test_reset_mid();
    test_early_ready();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares one `uart_tx` serial unit between `NREQ` byte-stream requesters. Each requester offers bytes with a valid/ready handshake and marks the final byte of a message with `last`. The arbiter locks the transmitter to one requester for a whole message, sequences `start`/`ready` with the `uart_tx` instance in the parent, and releases the grant at message end or on a hold timeout.

## Interface

Parameters:
- `NREQ`, 4: number of requesters, 2..8.
- `HOLD_MAX`, 0: cycles a granted requester may leave `req_valid` low mid-message before the grant is revoked. 0 means never revoke.

Ports (clock and reset first):
- `clk`  in  1  system clock; the block uses this single clock.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NREQ  requester i has a byte on offer.
- `req_data`  in  8*NREQ  byte of requester i on bits [8i+7:8i].
- `req_last`  in  NREQ  the offered byte is the last byte of requester i's message.
- `req_ready`  out  NREQ  combinational; a byte is accepted when `req_valid[i] & req_ready[i]`.
- `tx_data`  out  8  registered byte to `uart_tx.data`.
- `tx_start`  out  1  registered one-cycle pulse to `uart_tx.start`.
- `tx_ready`  in  1  `uart_tx.ready`; high means the transmitter is idle.
- `grant`  out  NREQ  registered, one-hot current owner; all zeros when there is no owner.
- `busy`  out  1  registered; high while any grant is held.
- `drop`  out  1  registered one-cycle pulse when a grant is revoked by timeout.

## Operation

- States: IDLE, SEND, WAIT_BUSY, WAIT_DONE.
- **IDLE**
  - If any `req_valid` is high, pick the first set bit searching upward from `ptr` with wrap.
  - Load `grant`, set `busy`, clear the hold counter, and go to SEND.
  - `ptr` resets to 0, so requester 0 has first priority.
- **SEND**
  - `req_ready[i] = grant[i] & tx_ready`, and is low in every other state.
  - On acceptance: latch `tx_data`, latch `last_q = req_last[owner]`, pulse `tx_start` on the next cycle, and go to WAIT_BUSY.
- **WAIT_BUSY**: wait for `tx_ready==0`, then go to WAIT_DONE. `tx_start` is never re-asserted while in this state.
- **WAIT_DONE**: wait for `tx_ready==1`.
  - If `last_q` is set: clear `grant` and `busy`, set `ptr = (owner+1) mod NREQ`, and go to IDLE.
  - Otherwise go to SEND.
- **Hold timeout**
  - In SEND with the owner's `req_valid` low, the hold counter increments each cycle.
  - When `HOLD_MAX != 0` and the count reaches `HOLD_MAX`: pulse `drop`, release the grant, advance `ptr` as at message end, and go to IDLE.
  - The counter clears on every acceptance.
- **Non-owners**: their `req_valid` is ignored, their `req_ready` stays 0, and they never preempt an owner mid-message.
- **Single-byte messages** (`req_last` set on the first byte) release the grant after one character.
- **Reset values**: `grant` 0, `busy` 0, `tx_start` 0, `tx_data` 8'h00, `drop` 0, `ptr` 0, state IDLE, hold counter 0.
- **Reset mid-operation**: `rst` aborts at once. No further `tx_start` is issued, and the character in flight is not retried. `uart_tx` shares `rst`.

## Timing

- Request to grant: `req_valid` seen in IDLE at cycle n gives `grant`/`busy` high at cycle n+1.
- First byte to start: with `tx_ready` high, the byte is accepted at n+1 and `tx_start` is high at n+2 for exactly one cycle.
- `tx_data` is stable from the `tx_start` cycle until the next acceptance.
- Back-to-back bytes within a message:
  - The next `req_ready` rises in the first cycle the block is in SEND, which is the cycle after `tx_ready` returns high.
  - The minimum gap between `tx_start` pulses is one character time plus 3 cycles.
- Release:
  - `grant` clears the cycle after WAIT_DONE sees `tx_ready` with `last_q`.
  - The next owner's grant appears one cycle later: one IDLE cycle is mandatory between owners.
- Timeout: `drop` and the grant clear occur together, `HOLD_MAX` cycles after the first cycle of SEND with the owner's `req_valid` low.

## Structure

- Shared package `uart_arb_pkg`: state encoding localparams and the `NREQ` bounds. The baud constants stay in the existing `baudgen.vh`.
- One sub-module, `rr_pick`: purely combinational. Inputs are a `NREQ`-bit request vector and `ptr`; outputs are a one-hot winner and its index.
- The parent instantiates `uart_tx` and wires `tx_*` to it. The arbiter contains no baud logic.

## Test plan

- **Single requester, 3 bytes**: req0 sends "A","B","C" with `last` on "C". Required: three `tx_start` pulses with `tx_data` 8'h41, 8'h42, 8'h43 in order, then `grant` 0 and `busy` 0.
- **Simultaneous requests**: req0–req3 all valid with one-byte messages "0".."3" from reset. Required: service order 0, 1, 2, 3. A second round with all valid again is also served 0, 1, 2, 3.
- **Message lock**: req1 owns a 2-byte message; req0 asserts valid during byte 1. Required: req1's second byte is sent before req0, and `req_ready[0]` stays 0 throughout.
- **Hold timeout, `HOLD_MAX=16`**: the owner sends 1 byte without `last`, then drops valid. Required: `drop` pulses 16 cycles into SEND, the grant clears, and the next requester is granted.
- **Reset mid-character**: assert `rst` for 1 cycle during WAIT_DONE. Required: the next cycle shows all outputs at reset values and no `tx_start` until a new request arrives.
- **Early `tx_ready`**: hold `tx_ready` high for 2 cycles after `tx_start`. Required: the block stays in WAIT_BUSY, issues no second `tx_start`, and `req_ready` stays 0.
